// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: per-entry state, entry record and
// the decoder command-type codes.
package rob_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2
  } rob_state_t;

  localparam int ROB_DATA_W = 64;

  localparam logic [2:0] CT_ALU   = 3'd0;
  localparam logic [2:0] CT_STUR  = 3'd1;
  localparam logic [2:0] CT_BCOND = 3'd3;
  localparam logic [2:0] CT_CBZ   = 3'd5;
  localparam logic [2:0] CT_BR    = 3'd6;
  localparam logic [2:0] CT_BL    = 3'd7;

  typedef struct packed {
    rob_state_t            state;
    logic [4:0]            regRD;
    logic                  regWrite;
    logic [2:0]            commandType;
    logic                  mispredict;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;

  function automatic rob_entry_t rob_empty_entry();
    rob_entry_t e;
    e = '0;
    return e;
  endfunction

endpackage

// File: rtl/rob_ptr.sv
// Wrap-around pointer register with increment enable and synchronous clear.
module rob_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  // Power-of-two depth lets the natural W-bit overflow provide the wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rob_commit_queue.sv
// In-order reorder buffer: program-order allocate, out-of-order writeback by
// tag, in-order retirement with a flush on a retiring mispredicted branch.
module rob_commit_queue
  import rob_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid_i,
  output logic              alloc_ready_o,
  input  logic [4:0]        alloc_regRD_i,
  input  logic              alloc_regWrite_i,
  input  logic [2:0]        alloc_commandType_i,
  output logic [TAG_W-1:0]  alloc_tag_o,
  input  logic              wb_valid_i,
  input  logic [TAG_W-1:0]  wb_tag_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              wb_mispredict_i,
  output logic              commit_valid_o,
  input  logic              commit_ready_i,
  output logic              commit_regWrite_o,
  output logic [4:0]        commit_regRD_o,
  output logic [DATA_W-1:0] commit_data_o,
  output logic [TAG_W-1:0]  commit_tag_o,
  output logic              flush_o,
  output logic [TAG_W:0]    count_o
);

  // Handshakes: a transfer fires on a cycle where valid and ready are both
  // high; valid never depends on ready, and offered fields hold until fire.

  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

  rob_entry_t       entries_q [DEPTH];
  rob_entry_t       entries_d [DEPTH];
  logic [TAG_W:0]   count_q, count_d;
  logic [TAG_W-1:0] head_q, tail_q;
  rob_entry_t       head_e;
  logic             alloc_fire, commit_fire;
  logic             unused_head_bits;

  assign head_e           = entries_q[head_q];
  assign unused_head_bits = ^head_e.commandType;

  assign commit_valid_o = !reset && (head_e.state == DONE);
  assign commit_fire    = commit_valid_o && commit_ready_i;
  assign flush_o        = commit_fire && head_e.mispredict;
  // Ready uses the pre-commit count, so a full queue never bypasses.
  assign alloc_ready_o  = !reset && (count_q < DEPTH_CNT) && !flush_o;
  assign alloc_fire     = alloc_valid_i && alloc_ready_o;

  assign alloc_tag_o       = tail_q;
  assign commit_tag_o      = head_q;
  assign commit_regWrite_o = head_e.regWrite;
  assign commit_regRD_o    = head_e.regRD;
  assign commit_data_o     = head_e.data[DATA_W-1:0];
  assign count_o           = count_q;

  rob_ptr #(.W(TAG_W)) u_head (
    .clk   (clk),
    .reset (reset),
    .clr_i (flush_o),
    .inc_i (commit_fire),
    .ptr_o (head_q)
  );

  rob_ptr #(.W(TAG_W)) u_tail (
    .clk   (clk),
    .reset (reset),
    .clr_i (flush_o),
    .inc_i (alloc_fire),
    .ptr_o (tail_q)
  );

  always_comb begin
    entries_d = entries_q;
    count_d   = count_q + {{TAG_W{1'b0}}, alloc_fire} - {{TAG_W{1'b0}}, commit_fire};
    if (flush_o) begin
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i] = rob_empty_entry();
      end
    end else begin
      // Writebacks only land on WAIT entries, so they never collide with the
      // DONE head being retired or the EMPTY slot being allocated.
      if (wb_valid_i && (entries_q[wb_tag_i].state == WAIT)) begin
        entries_d[wb_tag_i].state      = DONE;
        entries_d[wb_tag_i].data       = ROB_DATA_W'(wb_data_i);
        entries_d[wb_tag_i].mispredict = wb_mispredict_i;
      end
      if (commit_fire) begin
        entries_d[head_q] = rob_empty_entry();
      end
      if (alloc_fire) begin
        entries_d[tail_q]             = rob_empty_entry();
        entries_d[tail_q].state       = WAIT;
        entries_d[tail_q].regRD       = alloc_regRD_i;
        entries_d[tail_q].regWrite    = alloc_regWrite_i;
        entries_d[tail_q].commandType = alloc_commandType_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= rob_empty_entry();
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

endmodule
